// File: rtl/hazard_decoder_if.sv
// Observer-side view of the hazard-light bus: sampled pattern and strobe in,
// recovered mode, lock and error status out.
interface hazard_decoder_if;
    logic       tick;
    logic [2:0] lights;
    logic [1:0] mode;
    logic       locked;
    logic       err;

    modport master (
        output tick,
        output lights,
        input  mode,
        input  locked,
        input  err
    );

    modport slave (
        input  tick,
        input  lights,
        output mode,
        output locked,
        output err
    );
endinterface

// File: rtl/hazard_decoder.sv
// Classifies transitions between consecutive hazard-light patterns and locks
// onto the display mode once LOCK_COUNT same-class transitions are seen in a row.
module hazard_decoder #(
    parameter int LOCK_COUNT = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    hazard_decoder_if.slave bus
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCK
    } state_t;

    // The three directional classes share their encoding with the mode output.
    typedef enum logic [2:0] {
        TR_CALM   = 3'd0,
        TR_R2L    = 3'd1,
        TR_L2R    = 3'd2,
        TR_SWITCH = 3'd3,
        TR_HOLD   = 3'd4,
        TR_ERR    = 3'd5
    } trans_t;

    state_t     state_q, state_d;
    logic [2:0] prev_q, prev_d;
    logic       prev_valid_q, prev_valid_d;
    logic [1:0] cls_q, cls_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;

    trans_t     trans;
    logic [1:0] trans_cls;
    logic       cur_legal;
    logic [3:0] cnt_inc;

    function automatic logic is_legal(input logic [2:0] p);
        return (p == 3'b101) || (p == 3'b010) || (p == 3'b100) || (p == 3'b001);
    endfunction

    always_comb begin
        cur_legal = is_legal(bus.lights);
        if (!prev_valid_q || !cur_legal) begin
            trans = TR_ERR;
        end else if (bus.lights == prev_q) begin
            trans = TR_HOLD;
        end else begin
            unique case ({prev_q, bus.lights})
                6'b101_010, 6'b010_101:             trans = TR_CALM;
                6'b001_010, 6'b010_100, 6'b100_001: trans = TR_R2L;
                6'b100_010, 6'b010_001, 6'b001_100: trans = TR_L2R;
                default:                            trans = TR_SWITCH;
            endcase
        end
    end

    assign trans_cls = trans[1:0];

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        cls_d        = cls_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        cnt_inc      = (cnt_q >= LOCK_CNT) ? cnt_q : cnt_q + 4'd1;

        if (bus.tick) begin
            prev_d       = bus.lights;
            prev_valid_d = cur_legal;

            if (state_q == IDLE) begin
                if (cur_legal) begin
                    state_d = TRACK;
                    cnt_d   = 4'd0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (trans)
                    TR_CALM, TR_R2L, TR_L2R: begin
                        if (trans_cls == cls_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= LOCK_CNT) begin
                                state_d = LOCK;
                            end
                        end else begin
                            cls_d   = trans_cls;
                            cnt_d   = 4'd1;
                            state_d = (LOCK_CNT == 4'd1) ? LOCK : TRACK;
                        end
                    end
                    TR_HOLD: begin
                    end
                    TR_SWITCH: begin
                        cnt_d   = 4'd0;
                        state_d = TRACK;
                    end
                    default: begin
                        err_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = cur_legal ? TRACK : IDLE;
                    end
                endcase
            end
        end

        locked_d = (state_d == LOCK);
        mode_d   = (state_d == LOCK) ? cls_d : 2'b11;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            prev_q       <= 3'b000;
            prev_valid_q <= 1'b0;
            cls_q        <= 2'b00;
            cnt_q        <= 4'd0;
            mode_q       <= 2'b11;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            cls_q        <= cls_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign bus.mode   = mode_q;
    assign bus.locked = locked_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_hazard_decoder.sv
// Self-checking bench for hazard_decoder: directed scenarios followed by a
// randomized pattern walk, compared against a run-length model of the lights.
module tb_hazard_decoder;

    localparam int LOCK_COUNT = 3;

    logic Clock;
    logic Reset;

    hazard_decoder_if bus ();

    hazard_decoder #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Model: a transition either extends the current run of same-class
    // steps or restarts it; lock means the run has reached LOCK_COUNT.
    bit         m_synced;
    logic [2:0] m_prev;
    int         m_class;
    int         m_run;
    bit         m_err;

    logic [2:0] calm_seq [2] = '{3'b101, 3'b010};
    logic [2:0] r2l_seq  [3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0] l2r_seq  [3] = '{3'b100, 3'b010, 3'b001};
    logic [2:0] bad_pat  [4] = '{3'b000, 3'b011, 3'b110, 3'b111};

    function automatic bit legal(input logic [2:0] p);
        return (p == 3'b101) || (p == 3'b010) || (p == 3'b100) || (p == 3'b001);
    endfunction

    // 0 calm, 1 r2l, 2 l2r, 3 switch, 4 hold
    function automatic int kind(input logic [2:0] a, input logic [2:0] b);
        if (a == b) return 4;
        if ((a == 3'b101 && b == 3'b010) || (a == 3'b010 && b == 3'b101)) return 0;
        for (int i = 0; i < 3; i++) begin
            if (r2l_seq[i] == a && r2l_seq[(i + 1) % 3] == b) return 1;
            if (l2r_seq[i] == a && l2r_seq[(i + 1) % 3] == b) return 2;
        end
        return 3;
    endfunction

    function automatic bit exp_locked();
        return m_synced && (m_run >= LOCK_COUNT);
    endfunction

    function automatic logic [1:0] exp_mode();
        return exp_locked() ? 2'(m_class) : 2'b11;
    endfunction

    task automatic modelReset();
        m_synced = 1'b0;
        m_prev   = 3'b000;
        m_class  = 0;
        m_run    = 0;
        m_err    = 1'b0;
    endtask

    task automatic modelTick(input logic [2:0] cur);
        int k;
        m_err = !legal(cur);
        if (!m_synced) begin
            if (legal(cur)) begin
                m_synced = 1'b1;
                m_run    = 0;
            end
        end else if (!legal(cur)) begin
            m_synced = 1'b0;
            m_run    = 0;
        end else begin
            k = kind(m_prev, cur);
            if (k == 3) begin
                m_run = 0;
            end else if (k < 3) begin
                if (k == m_class) begin
                    m_run++;
                end else begin
                    m_class = k;
                    m_run   = 1;
                end
            end
        end
        m_prev = cur;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".mode"},   {2'b00, bus.mode},   {2'b00, exp_mode()});
        checkOutput({tag, ".locked"}, {3'b000, bus.locked}, {3'b000, exp_locked()});
        checkOutput({tag, ".err"},    {3'b000, bus.err},    {3'b000, m_err});
    endtask

    task automatic applyStimulus(input logic [2:0] pat, input bit do_tick, input string tag);
        @(negedge Clock);
        bus.tick   = do_tick;
        bus.lights = pat;
        @(posedge Clock);
        #1;
        bus.tick = 1'b0;
        if (do_tick) modelTick(pat);
        else         m_err = 1'b0;
        checkModel(tag);
    endtask

    task automatic doReset();
        @(negedge Clock);
        Reset = 1'b0;
        modelReset();
        #1;
        checkModel("reset");
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic expectState(input string tag, input bit lk, input logic [1:0] md, input bit er);
        checkOutput({tag, ".locked"}, {3'b000, bus.locked}, {3'b000, lk});
        checkOutput({tag, ".mode"},   {2'b00, bus.mode},    {2'b00, md});
        checkOutput({tag, ".err"},    {3'b000, bus.err},    {3'b000, er});
    endtask

    int         gen_mode;
    int         gen_idx;
    logic [2:0] last_pat;
    logic [2:0] pat;
    int         r;

    initial begin
        Reset      = 1'b1;
        bus.tick   = 1'b0;
        bus.lights = 3'b000;
        modelReset();
        #2 Reset = 1'b0;
        #1;
        expectState("por", 1'b0, 2'b11, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;

        // Calm lock
        applyStimulus(3'b101, 1'b1, "calm0");
        applyStimulus(3'b010, 1'b1, "calm1");
        applyStimulus(3'b101, 1'b1, "calm2");
        expectState("calm_prelock", 1'b0, 2'b11, 1'b0);
        applyStimulus(3'b010, 1'b1, "calm3");
        expectState("calm_lock", 1'b1, 2'b00, 1'b0);

        // Direction reversal
        doReset();
        applyStimulus(3'b001, 1'b1, "r2l0");
        applyStimulus(3'b010, 1'b1, "r2l1");
        applyStimulus(3'b100, 1'b1, "r2l2");
        applyStimulus(3'b001, 1'b1, "r2l3");
        expectState("r2l_lock", 1'b1, 2'b01, 1'b0);
        applyStimulus(3'b100, 1'b1, "rev0");
        expectState("rev_unlock", 1'b0, 2'b11, 1'b0);
        applyStimulus(3'b010, 1'b1, "rev1");
        applyStimulus(3'b001, 1'b1, "rev2");
        expectState("l2r_lock", 1'b1, 2'b10, 1'b0);

        // Hold and gating
        doReset();
        foreach (r2l_seq[i]) applyStimulus(r2l_seq[i], 1'b1, "hold_pre");
        foreach (r2l_seq[i]) applyStimulus(r2l_seq[i], 1'b1, "hold_pre");
        for (int i = 0; i < 10; i++) applyStimulus(3'b100, 1'b1, "hold");
        expectState("hold_lock", 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(3'($urandom), 1'b0, "gate");
        expectState("gate_lock", 1'b1, 2'b01, 1'b0);

        // Illegal pattern
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(calm_seq[i % 2], 1'b1, "ill_pre");
        applyStimulus(3'b111, 1'b1, "ill");
        expectState("ill_err", 1'b0, 2'b11, 1'b1);
        applyStimulus(3'b010, 1'b1, "ill_next");
        expectState("ill_clear", 1'b0, 2'b11, 1'b0);

        // SWITCH step
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(calm_seq[i % 2], 1'b1, "sw_pre");
        applyStimulus(3'b101, 1'b1, "sw0");
        applyStimulus(3'b001, 1'b1, "sw1");
        expectState("sw_unlock", 1'b0, 2'b11, 1'b0);
        applyStimulus(3'b010, 1'b1, "sw2");
        applyStimulus(3'b100, 1'b1, "sw3");
        applyStimulus(3'b001, 1'b1, "sw4");
        expectState("sw_lock", 1'b1, 2'b01, 1'b0);

        // Async reset mid-cycle while locked
        @(posedge Clock);
        #3 Reset = 1'b0;
        #1;
        expectState("async_rst", 1'b0, 2'b11, 1'b0);
        modelReset();
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < LOCK_COUNT; i++) applyStimulus(calm_seq[i % 2], 1'b1, "post_rst");
        expectState("post_rst_nolock", 1'b0, 2'b11, 1'b0);
        applyStimulus(calm_seq[LOCK_COUNT % 2], 1'b1, "post_rst_last");
        expectState("post_rst_lock", 1'b1, 2'b00, 1'b0);

        // Randomized walk through the three modes with holds, glitches and gaps
        gen_mode = 0;
        gen_idx  = 0;
        last_pat = 3'b101;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(99);
            if (r < 6) gen_mode = $urandom_range(2);
            if (r < 5) begin
                pat = bad_pat[$urandom_range(3)];
            end else if (r < 15) begin
                pat = last_pat;
            end else if (r < 20) begin
                pat = 3'($urandom);
            end else begin
                gen_idx++;
                case (gen_mode)
                    0:       pat = calm_seq[gen_idx % 2];
                    1:       pat = r2l_seq[gen_idx % 3];
                    default: pat = l2r_seq[gen_idx % 3];
                endcase
            end
            if ($urandom_range(3) != 0) begin
                applyStimulus(pat, 1'b1, "rand");
                last_pat = pat;
            end else begin
                applyStimulus(3'($urandom), 1'b0, "rand_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
